i2c_tx_serializer: RTL and testbench
====================================

Name: i2c_tx_serializer

Overview:
- Read-side consumer of the 8-entry I2C transmit FIFO.
- Pops bytes from the FIFO's show-ahead read port and loads them into a shift register.
- Drives them MSB-first onto the SDA transmit path, one bit per timing-unit strobe, and samples the slave ACK after each byte.
- Sits between the TX FIFO and the I2C bus/timing unit inside the I2C controller.

Parameters:
- CNT_W, 6, width of byte_count and bytes_sent (maximum transfer = 2^CNT_W-1 bytes)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  one-cycle pulse; begins a transfer of byte_count bytes
- byte_count  input  CNT_W  bytes to send; latched on accepted start
- fifo_empty  input  1  TX FIFO empty flag
- fifo_r_data  input  8  TX FIFO head byte (show-ahead, valid when !fifo_empty)
- fifo_r_enable  output  1  one-cycle pop request to TX FIFO
- shift_strobe  input  1  one-cycle pulse marking end of each SCL bit slot
- ack_in  input  1  sampled SDA during ACK slot (0 = ACK, 1 = NACK)
- sda_out  output  1  transmit bit (1 = release line)
- busy  output  1  high from accepted start until return to IDLE
- done  output  1  one-cycle pulse on successful completion
- nack_err  output  1  one-cycle pulse when a NACK is received
- underrun  output  1  sticky; set on FIFO underrun, cleared by next accepted start
- bytes_sent  output  CNT_W  bytes ACKed in current or last transfer

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, sda_out=1, fifo_r_enable=0, busy=0, done=0, nack_err=0, underrun=0, bytes_sent=0, shift reg=0, bit counter=0.
- Register-driven outputs: sda_out, busy and fifo_r_enable decode from registered state/shift register only. There is no combinational path from any input.
- States: IDLE, FETCH, SHIFT, ACK.
- IDLE:
  - sda_out=1.
  - start with byte_count!=0: latch count, clear bytes_sent and underrun, go to FETCH next cycle.
  - start with byte_count==0: done pulses the next cycle, state stays IDLE, bytes_sent cleared.
- FETCH:
  - If !fifo_empty: fifo_r_enable=1 for exactly this cycle, shift reg<=fifo_r_data, bit counter<=0, go to SHIFT.
  - A shift_strobe in the same cycle as a pop is ignored. The timing unit guarantees at least 2 clk between the ACK-slot strobe and the next strobe.
  - If fifo_empty and shift_strobe: set underrun, go to IDLE, no done.
  - If fifo_empty and no strobe: wait.
- SHIFT:
  - sda_out = shift reg[7].
  - On shift_strobe with bit counter<7: shift left 1, bit counter++.
  - On shift_strobe with bit counter==7: go to ACK.
  - First bit appears on sda_out 1 clk after the pop cycle.
- ACK:
  - sda_out=1 (released).
  - On shift_strobe with ack_in=1: nack_err pulses next cycle, go to IDLE, bytes_sent unchanged.
  - On shift_strobe with ack_in=0: bytes_sent++. If the new value equals the latched count, done pulses and state goes to IDLE; otherwise go to FETCH.
- busy = (state != IDLE).
- Conflicting inputs:
  - start while busy is ignored.
  - byte_count changes after latch have no effect.
- Pulse width: done and nack_err are exactly one clk, registered, and mutually exclusive.
- Reset mid-transfer: immediate return to reset values. No pop is issued, and the FIFO is not drained.
- Pop discipline:
  - At most one pop per byte.
  - Never pop while fifo_empty.
  - Never pop outside FETCH.

Test Plan:
- Reset: assert rst mid-SHIFT -> sda_out=1, busy=0, fifo_r_enable=0 immediately; underrun=0, bytes_sent=0.
- Single byte: FIFO holds 0xA5, byte_count=1, start, 9 strobes with ack_in=0 on the 9th:
  - sda_out sequence 1,0,1,0,0,1,0,1 then released;
  - exactly one fifo_r_enable pulse;
  - done pulses once; bytes_sent=1.
- Multi-byte: FIFO holds 0x3C,0xFF,0x00, byte_count=3, all ACKed -> 3 pops, bit streams match MSB-first, done after 27th strobe, bytes_sent=3.
- NACK: byte_count=2, first byte ACKed, second NACKed -> nack_err pulses once, no done, bytes_sent=1, busy drops, second byte was popped.
- Underrun: byte_count=2, FIFO holds 1 byte, strobe arrives in FETCH with fifo_empty=1 -> underrun=1 (sticky), busy=0, no pop while empty; next start clears underrun.
- Edge cases:
  - byte_count=0 start -> done pulse, no pop, busy stays 0.
  - start during busy -> ignored, transfer unaffected.

Source files
------------

// File: rtl/i2c_tx_serializer.sv
// Byte serializer for the I2C transmit path: pops bytes from the show-ahead TX FIFO,
// shifts them MSB-first onto SDA one bit per timing strobe and samples the slave ACK.
module i2c_tx_serializer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] byte_count,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_r_data,
    output logic             fifo_r_enable,
    input  logic             shift_strobe,
    input  logic             ack_in,
    output logic             sda_out,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic             underrun,
    output logic [CNT_W-1:0] bytes_sent
);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, ACK} state_t;

    state_t           state, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sent_d;
    logic             done_d, nack_d, underrun_d;
    logic             empty_q;

    // Only this block drains the FIFO, so a one-cycle-old "not empty" can never be stale
    // while waiting in FETCH; using it keeps fifo_r_enable free of input-to-output paths.
    assign fifo_r_enable = (state == FETCH) && !empty_q;
    assign busy          = (state != IDLE);
    assign sda_out       = (state == SHIFT) ? shift_q[7] : 1'b1;

    // NOTE: every sequential register, including the shift register, has a defined reset value
    // and is updated with non-blocking assignments so all state advances together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            count_q    <= '0;
            bytes_sent <= '0;
            done       <= 1'b0;
            nack_err   <= 1'b0;
            underrun   <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            state      <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            count_q    <= count_d;
            bytes_sent <= sent_d;
            done       <= done_d;
            nack_err   <= nack_d;
            underrun   <= underrun_d;
            empty_q    <= fifo_empty;
        end
    end

    // NOTE: every value written here is given a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        count_d    = count_q;
        sent_d     = bytes_sent;
        done_d     = 1'b0;
        nack_d     = 1'b0;
        underrun_d = underrun;

        case (state)
            IDLE: begin
                if (start) begin
                    sent_d = '0;
                    if (byte_count != '0) begin
                        count_d    = byte_count;
                        underrun_d = 1'b0;
                        state_d    = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                // A pop takes priority; a strobe landing on the pop cycle is dropped.
                if (fifo_r_enable) begin
                    shift_d   = fifo_r_data;
                    bit_cnt_d = 3'd0;
                    state_d   = SHIFT;
                end else if (shift_strobe) begin
                    underrun_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            SHIFT: begin
                if (shift_strobe) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ACK: begin
                if (shift_strobe) begin
                    if (ack_in) begin
                        nack_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sent_d = bytes_sent + 1'b1;
                        if (sent_d == count_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_tx_serializer.sv
// Directed bench for i2c_tx_serializer: a FIFO model feeds bytes, expected SDA bits are
// queued on push and compared bit-by-bit as the serializer shifts them out.
module tb_i2c_tx_serializer;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] byte_count = '0;
    logic             fifo_empty = 1'b1;
    logic [7:0]       fifo_r_data = 8'h00;
    logic             fifo_r_enable;
    logic             shift_strobe = 1'b0;
    logic             ack_in = 1'b0;
    logic             sda_out;
    logic             busy;
    logic             done;
    logic             nack_err;
    logic             underrun;
    logic [CNT_W-1:0] bytes_sent;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    int bad_pops = 0;
    int done_cnt = 0;
    int nack_cnt = 0;

    logic [7:0] fq[$];
    logic       exp_q[$];

    i2c_tx_serializer #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_count   (byte_count),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_enable(fifo_r_enable),
        .shift_strobe (shift_strobe),
        .ack_in       (ack_in),
        .sda_out      (sda_out),
        .busy         (busy),
        .done         (done),
        .nack_err     (nack_err),
        .underrun     (underrun),
        .bytes_sent   (bytes_sent)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model; writes become visible on the following edge.
    always @(posedge clk) begin
        if (fifo_r_enable) begin
            pops++;
            if (fifo_empty || fq.size() == 0) bad_pops++;
            else void'(fq.pop_front());
        end
        if (done) done_cnt++;
        if (nack_err) nack_cnt++;
        fifo_empty  <= (fq.size() == 0);
        fifo_r_data <= (fq.size() != 0) ? fq[0] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fq.push_back(b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] n);
        byte_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe();
        shift_strobe = 1'b1;
        tick();
        shift_strobe = 1'b0;
    endtask

    task automatic send_bits();
        logic e;
        for (int i = 0; i < 8; i++) begin
            repeat (3) tick();
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
            check("sda_bit", sda_out, e);
            strobe();
        end
    endtask

    task automatic ack_slot(input logic a);
        repeat (3) tick();
        check("sda_ack_released", sda_out, 1);
        ack_in = a;
        strobe();
        ack_in = 1'b0;
    endtask

    initial begin
        int p0, d0, n0;
        logic e;

        // Reset values
        repeat (2) tick();
        check("rst_sda", sda_out, 1);
        check("rst_busy", busy, 0);
        check("rst_pop", fifo_r_enable, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack_err, 0);
        check("rst_underrun", underrun, 0);
        check("rst_bytes_sent", bytes_sent, 0);
        rst = 1'b0;
        tick();

        // Single byte 0xA5
        push_byte(8'hA5);
        tick();
        p0 = pops; d0 = done_cnt;
        pulse_start(1);
        check("single_busy", busy, 1);
        send_bits();
        ack_slot(1'b0);
        check("single_done", done, 1);
        check("single_busy_drop", busy, 0);
        check("single_bytes_sent", bytes_sent, 1);
        tick();
        check("single_done_width", done, 0);
        check("single_pops", pops - p0, 1);
        check("single_done_count", done_cnt - d0, 1);
        check("single_exp_drained", exp_q.size(), 0);

        // Multi-byte with an ignored start mid-transfer
        push_byte(8'h3C); push_byte(8'hFF); push_byte(8'h00);
        tick();
        p0 = pops; d0 = done_cnt;
        pulse_start(3);
        send_bits();
        ack_slot(1'b0);
        check("multi_sent_after_1", bytes_sent, 1);
        check("multi_busy_mid", busy, 1);
        pulse_start(5);
        send_bits();
        ack_slot(1'b0);
        check("multi_no_early_done", done, 0);
        send_bits();
        ack_slot(1'b0);
        check("multi_done", done, 1);
        check("multi_bytes_sent", bytes_sent, 3);
        check("multi_busy_drop", busy, 0);
        tick();
        check("multi_pops", pops - p0, 3);
        check("multi_done_count", done_cnt - d0, 1);

        // NACK on second byte
        push_byte(8'h11); push_byte(8'h22);
        tick();
        p0 = pops; d0 = done_cnt; n0 = nack_cnt;
        pulse_start(2);
        send_bits();
        ack_slot(1'b0);
        send_bits();
        ack_slot(1'b1);
        check("nack_pulse", nack_err, 1);
        check("nack_no_done", done, 0);
        check("nack_busy_drop", busy, 0);
        check("nack_bytes_sent", bytes_sent, 1);
        tick();
        check("nack_width", nack_err, 0);
        check("nack_count", nack_cnt - n0, 1);
        check("nack_done_count", done_cnt - d0, 0);
        check("nack_pops", pops - p0, 2);

        // Underrun: two bytes requested, one supplied
        push_byte(8'hC3);
        tick();
        p0 = pops; d0 = done_cnt;
        pulse_start(2);
        send_bits();
        ack_slot(1'b0);
        repeat (3) tick();
        check("underrun_wait_no_pop", fifo_r_enable, 0);
        check("underrun_wait_sda", sda_out, 1);
        check("underrun_wait_busy", busy, 1);
        strobe();
        check("underrun_set", underrun, 1);
        check("underrun_busy_drop", busy, 0);
        check("underrun_bytes_sent", bytes_sent, 1);
        repeat (4) tick();
        check("underrun_sticky", underrun, 1);
        check("underrun_no_done", done_cnt - d0, 0);
        check("underrun_pops", pops - p0, 1);

        // Next start clears underrun
        push_byte(8'h5A);
        tick();
        pulse_start(1);
        check("underrun_cleared", underrun, 0);
        check("restart_sent_cleared", bytes_sent, 0);
        send_bits();
        ack_slot(1'b0);
        check("restart_done", done, 1);
        check("restart_bytes_sent", bytes_sent, 1);
        tick();

        // Zero-length transfer
        p0 = pops; d0 = done_cnt;
        pulse_start(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_bytes_sent", bytes_sent, 0);
        tick();
        check("zero_done_width", done, 0);
        check("zero_busy_after", busy, 0);
        check("zero_pops", pops - p0, 0);
        check("zero_done_count", done_cnt - d0, 1);

        // Reset mid-SHIFT of the second byte
        push_byte(8'h81); push_byte(8'h7F);
        tick();
        p0 = pops;
        pulse_start(2);
        send_bits();
        ack_slot(1'b0);
        check("midrst_sent_before", bytes_sent, 1);
        repeat (3) tick();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        check("midrst_sda_before", sda_out, e);
        rst = 1'b1;
        #1;
        check("midrst_sda", sda_out, 1);
        check("midrst_busy", busy, 0);
        check("midrst_pop", fifo_r_enable, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_bytes_sent", bytes_sent, 0);
        repeat (3) tick();
        check("midrst_pops", pops - p0, 2);
        rst = 1'b0;
        exp_q.delete();
        fq.delete();
        repeat (2) tick();

        check("never_pop_empty", bad_pops, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
